ttt_button_conditioner: RTL and testbench

- Conditions the five raw Nexys push-buttons (BtnL, BtnR, BtnU, BtnD, BtnC) into clean inputs for the tic-tac-toe game core.
- Per button: two-flop synchronizer plus debounce state machine.
- Outputs one-clock press pulses and debounced levels; the core's state machine consumes these directly.
- Sits between the board pins and `ee354_tictactoe` in the top level.

---
 rtl/ttt_button_conditioner.sv | 154 +++++++++++++++
 tb/tb_ttt_button_conditioner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_button_conditioner.sv
// ttt_button_conditioner: five-way push-button synchronizer + debouncer for the tic-tac-toe core.
// Latency: press pulse in the cycle after edge e0+DEBOUNCE_CYCLES+2 (e0 = first raw=1 sample).
// Backpressure: none; pulses are one-clock strobes that the consumer must take when they appear.
//
// Ports:
//   Clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high
//   btn_raw    asynchronous pins: [4]=BtnL [3]=BtnR [2]=BtnU [1]=BtnD [0]=BtnC
//   btn_pulse  one-clock press strobe per button (state decode, no path from btn_raw)
//   btn_level  debounced pressed level per button (state decode)
//   btn_any    OR of btn_pulse, valid in the same cycle as btn_pulse
//
// Build option: define TTT_BTN_AUTOREPEAT_EN to compile in the held-button auto-repeat
// for bits [4:1] (cursor movement). BtnC never repeats. Without it, one pulse per press.

module ttt_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000,
  parameter int CNT_W           = 25
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_pulse,
  output logic [4:0] btn_level,
  output logic       btn_any
);

  // Elaboration-time sanity check of the parameter set.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 ||
      (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
      (64'd1 << CNT_W) <= 64'(REPEAT_CYCLES)) begin : g_bad_params
    $error("ttt_button_conditioner: illegal DEBOUNCE_CYCLES/REPEAT_CYCLES/CNT_W");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WQ    = 3'd1,  // wait for the press to stay quiet
    PULSE = 3'd2,
    HELD  = 3'd3,
    WR    = 3'd4   // wait for the release to stay quiet
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef TTT_BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  for (genvar i = 0; i < 5; i++) begin : g_btn
    logic             s1;
    logic             s2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             pulse_q;
    logic             level_q;

    // Saturating increment: a button held forever (no repeat) must not wrap the counter.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    // State register, counter and two-flop synchronizer.
    always_ff @(posedge Clk) begin
      if (reset) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        state <= IDLE;
        cnt   <= '0;
      end else begin
        s1    <= btn_raw[i];
        s2    <= s1;
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // Next-state and counter update, all decisions on the synced sample s2.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
        IDLE: begin
          if (s2) begin
            state_nxt = WQ;
            cnt_nxt   = '0;
          end
        end
        WQ: begin
          if (!s2)                  state_nxt = IDLE;
          else if (cnt == DEB_LAST) state_nxt = PULSE;
          else                      cnt_nxt   = cnt_inc;
        end
        PULSE: begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end
        HELD: begin
          if (!s2) begin
            state_nxt = WR;
            cnt_nxt   = '0;
          end
`ifdef TTT_BTN_AUTOREPEAT_EN
          // BtnC places a mark, so only the cursor buttons repeat.
          else if (i != 0 && cnt == REP_LAST) begin
            state_nxt = PULSE;
          end
`endif
          else begin
            cnt_nxt = cnt_inc;
          end
        end
        WR: begin
          // A bounce back to 1 returns to HELD silently; no second pulse.
          if (s2) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    // Outputs decode the state flops only.
    always_comb begin
      pulse_q = 1'b0;
      level_q = 1'b0;
      case (state)
        PULSE: begin
          pulse_q = 1'b1;
          level_q = 1'b1;
        end
        HELD, WR: level_q = 1'b1;
        default: begin
          pulse_q = 1'b0;
          level_q = 1'b0;
        end
      endcase
    end

    assign btn_pulse[i] = pulse_q;
    assign btn_level[i] = level_q;
  end

  assign btn_any = |btn_pulse;

endmodule

// File: tb/tb_ttt_button_conditioner.sv
// Testbench for ttt_button_conditioner: table vectors, corner sequences, randomized run vs model.
// Latency: checks every cycle, 1 ns after the rising edge.
// Backpressure: not applicable.

module tb_ttt_button_conditioner;

  localparam int D = 4;
  localparam int R = 10;

`ifdef TTT_BTN_AUTOREPEAT_EN
  localparam bit [4:0] REP_MASK = 5'b11110;
`else
  localparam bit [4:0] REP_MASK = 5'b00000;
`endif

  logic       Clk;
  logic       reset;
  logic [4:0] btn_raw;
  logic [4:0] btn_pulse;
  logic [4:0] btn_level;
  logic       btn_any;

  ttt_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R),
    .CNT_W          (8)
  ) dut (
    .Clk      (Clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level),
    .btn_any  (btn_any)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Reference model: run lengths of synced samples rather than an explicit state machine.
  bit [4:0] m_s1, m_s2, m_pend, m_lvl;
  int       one_run [5];
  int       zero_run[5];
  int       rep     [5];

  task automatic model_step(input bit [4:0] raw, input bit rst);
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_pend = '0; m_lvl = '0;
      for (int i = 0; i < 5; i++) begin
        one_run[i] = 0; zero_run[i] = 0; rep[i] = 0;
      end
      return;
    end
    for (int i = 0; i < 5; i++) begin
      bit x;
      x = m_s2[i];
      if (m_pend[i]) begin
        // strobe lasts one cycle whatever the input does
        m_pend[i] = 1'b0; rep[i] = 0; zero_run[i] = 0;
      end else if (!m_lvl[i]) begin
        if (x) begin
          one_run[i]++;
          if (one_run[i] == D + 1) begin
            m_pend[i] = 1'b1; m_lvl[i] = 1'b1; one_run[i] = 0;
          end
        end else begin
          one_run[i] = 0;
        end
      end else begin
        if (!x) begin
          zero_run[i]++; rep[i] = 0;
          if (zero_run[i] == D + 1) begin
            m_lvl[i] = 1'b0; zero_run[i] = 0;
          end
        end else if (zero_run[i] > 0) begin
          zero_run[i] = 0; rep[i] = 0;
        end else begin
          rep[i]++;
          if (REP_MASK[i] && rep[i] == R) begin
            m_pend[i] = 1'b1; rep[i] = 0;
          end
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare against it.
  task automatic tick(input bit [4:0] raw, input bit rst);
    btn_raw = raw;
    reset   = rst;
    @(posedge Clk);
    #1;
    model_step(raw, rst);
    chk("model_pulse", btn_pulse, m_pend);
    chk("model_level", btn_level, m_lvl);
    chk("model_any", {4'b0, btn_any}, {4'b0, |m_pend});
  endtask

  typedef struct {
    bit       rst;
    bit [4:0] raw;
    int       n;
    bit [4:0] pulse;
    bit [4:0] level;
    bit       any;
  } vec_t;

  vec_t vt[$];

  initial begin
    int       pcnt;
    int       first;
    bit       dropped;
    bit [4:0] r;
    bit [4:0] cap;
    int       rate;
    int       got_idx[$];
    int       exp_idx[$];

    btn_raw = '0;
    reset   = 1'b1;

    // Clean press on BtnC (pulse after e6, release falls 6 edges after first low)
    vt.push_back('{1'b1, 5'b00000,  2, 5'b00000, 5'b00000, 1'b0});
    vt.push_back('{1'b0, 5'b00001,  6, 5'b00000, 5'b00000, 1'b0});
    vt.push_back('{1'b0, 5'b00001,  1, 5'b00001, 5'b00001, 1'b1});
    vt.push_back('{1'b0, 5'b00001, 23, 5'b00000, 5'b00001, 1'b0});
    vt.push_back('{1'b0, 5'b00000,  6, 5'b00000, 5'b00001, 1'b0});
    vt.push_back('{1'b0, 5'b00000,  4, 5'b00000, 5'b00000, 1'b0});
    // Short glitch on BtnR
    vt.push_back('{1'b0, 5'b01000,  3, 5'b00000, 5'b00000, 1'b0});
    vt.push_back('{1'b0, 5'b00000,  8, 5'b00000, 5'b00000, 1'b0});
    // Press bounce on BtnU, then stable high from ek
    for (int k = 0; k < 6; k++)
      vt.push_back('{1'b0, (k % 2 == 0) ? 5'b00100 : 5'b00000, 1, 5'b00000, 5'b00000, 1'b0});
    vt.push_back('{1'b0, 5'b00100,  6, 5'b00000, 5'b00000, 1'b0});
    vt.push_back('{1'b0, 5'b00100,  1, 5'b00100, 5'b00100, 1'b1});
    vt.push_back('{1'b0, 5'b00100,  5, 5'b00000, 5'b00100, 1'b0});
    vt.push_back('{1'b0, 5'b00000,  6, 5'b00000, 5'b00100, 1'b0});
    vt.push_back('{1'b0, 5'b00000,  4, 5'b00000, 5'b00000, 1'b0});

    foreach (vt[v]) begin
      for (int k = 0; k < vt[v].n; k++) begin
        tick(vt[v].raw, vt[v].rst);
        chk($sformatf("vec%0d_pulse", v), btn_pulse, vt[v].pulse);
        chk($sformatf("vec%0d_level", v), btn_level, vt[v].level);
        chk($sformatf("vec%0d_any", v), {4'b0, btn_any}, {4'b0, vt[v].any});
      end
    end

    // Release bounce: held BtnC drops for 2 clocks, level must hold, no second pulse
    pcnt = 0; dropped = 1'b0;
    for (int k = 0; k < 22; k++) begin
      tick((k >= 10 && k < 12) ? 5'b00000 : 5'b00001, 1'b0);
      if (btn_pulse[0]) pcnt++;
      if (k >= 6 && !btn_level[0]) dropped = 1'b1;
    end
    chk_int("bounce_pulses", pcnt, 1);
    chk_int("bounce_level_drop", int'(dropped), 0);
    first = -1;
    for (int k = 0; k < 10; k++) begin
      tick(5'b00000, 1'b0);
      if (first < 0 && !btn_level[0]) first = k;
    end
    chk_int("release_fall_edge", first, 6);

    // Auto-repeat on BtnL
    got_idx.delete();
    for (int k = 0; k < 50; k++) begin
      tick(5'b10000, 1'b0);
      if (btn_pulse[4]) got_idx.push_back(k);
    end
`ifdef TTT_BTN_AUTOREPEAT_EN
    exp_idx = '{6, 17, 28, 39};
`else
    exp_idx = '{6};
`endif
    chk_int("repeat_count", got_idx.size(), exp_idx.size());
    for (int j = 0; j < exp_idx.size() && j < got_idx.size(); j++)
      chk_int($sformatf("repeat_edge%0d", j), got_idx[j], exp_idx[j]);
    for (int k = 0; k < 10; k++) tick(5'b00000, 1'b0);

    // BtnC held long never repeats
    pcnt = 0;
    for (int k = 0; k < 50; k++) begin
      tick(5'b00001, 1'b0);
      if (btn_pulse[0]) pcnt++;
    end
    chk_int("btnc_no_repeat", pcnt, 1);
    for (int k = 0; k < 10; k++) tick(5'b00000, 1'b0);

    // Simultaneous L and D presses
    cap = '0;
    for (int k = 0; k < 10; k++) begin
      tick(5'b10010, 1'b0);
      if (k == 6) cap = btn_pulse;
    end
    chk("simul_pulse", cap, 5'b10010);

    // Reset while HELD: outputs clear on first reset edge, then one fresh pulse
    tick(5'b10010, 1'b1);
    chk("reset_pulse", btn_pulse, 5'b00000);
    chk("reset_level", btn_level, 5'b00000);
    chk("reset_any", {4'b0, btn_any}, 5'b00000);
    tick(5'b10010, 1'b1);
    first = -1; pcnt = 0; cap = '0;
    for (int k = 0; k < 12; k++) begin
      tick(5'b10010, 1'b0);
      if (btn_any) begin
        pcnt++;
        if (first < 0) begin first = k; cap = btn_pulse; end
      end
    end
    chk_int("post_reset_pulse_edge", first, 6);
    chk_int("post_reset_pulse_count", pcnt, 1);
    chk("post_reset_pulse_bits", cap, 5'b10010);
    for (int k = 0; k < 10; k++) tick(5'b00000, 1'b0);

    // Randomized run against the model: alternate bouncy and slow segments
    r = '0;
    for (int seg = 0; seg < 10; seg++) begin
      rate = (seg % 2 == 0) ? 6 : 40;
      for (int k = 0; k < 300; k++) begin
        for (int i = 0; i < 5; i++)
          if ($urandom_range(rate - 1) == 0) r[i] = ~r[i];
        tick(r, $urandom_range(499) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
